rsa_res_collect: RTL
====================

RSA_RES_COLLECT -- requirements
Module: rsa_res_collect

Interface
REQ-001 SHALL have parameter RSA_DW, default 32, meaning the result word width in bits, signed Q1.12.19.
REQ-002 SHALL have parameter ROW_LEN, default 4, meaning the number of results per burst (PE columns per row); the legal range is 2..64.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the result buffer depth; it SHALL be a power of two and at least 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port mulres_val_in, input, 1 bit: a result beat is valid this cycle; driven by the west-most PE's mulres_val_W.
REQ-007 Port mulres_in, input, RSA_DW bits, signed: the result beat; driven by the west-most PE's mulres_W.
REQ-008 Port out_valid, output, 1 bit: out_data and out_last are valid.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the head word.
REQ-010 Port out_data, output, RSA_DW bits, signed: the head result word.
REQ-011 Port out_last, output, 1 bit: the head word is the final word of its burst.
REQ-012 Port clr, input, 1 bit: synchronous clear of the sticky flags and burst_cnt.
REQ-013 Port overflow, output, 1 bit: sticky; a beat was dropped.
REQ-014 Port err_short, output, 1 bit: one-cycle pulse; a burst ended before ROW_LEN beats.
REQ-015 Port burst_cnt, output, 16 bits: number of completed full bursts, wrapping.

Function
REQ-016 Input beats SHALL NOT be back-pressured; the array cannot stall.
REQ-017 A beat SHALL be written when mulres_val_in=1 and either the FIFO count is below FIFO_DEPTH or a read occurs in the same cycle.
REQ-018 Otherwise the beat SHALL be dropped and overflow SHALL be set to 1.
REQ-019 A read SHALL occur when out_valid=1 and out_ready=1; out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-020 The FIFO SHALL be first-word-fall-through: a beat written at edge N SHALL appear on out_valid/out_data after edge N (1 cycle latency) when the FIFO was empty.
REQ-021 Reading an empty FIFO SHALL have no effect; out_valid SHALL be 0 exactly when the count is 0.
REQ-022 A beat counter beat_idx (0..ROW_LEN-1) SHALL advance on every valid beat, whether stored or dropped, and SHALL wrap to 0 after ROW_LEN-1.
REQ-023 A stored word's last flag SHALL be 1 iff beat_idx==ROW_LEN-1 at the cycle it is written.
REQ-024 The FSM SHALL have two states, IDLE and COLLECT.
REQ-025 IDLE->COLLECT SHALL occur on a valid beat when ROW_LEN>1.
REQ-026 COLLECT->IDLE SHALL occur on the ROW_LEN-1 beat; burst_cnt SHALL increment by 1 at that edge.
REQ-027 COLLECT with mulres_val_in=0 SHALL go to IDLE, reset beat_idx to 0, and raise err_short for one cycle.
REQ-028 Words already stored SHALL be kept when a burst ends short.
REQ-029 clr=1 SHALL zero overflow and burst_cnt at the next edge; clr has priority over a same-cycle set or increment.
REQ-030 Pointers SHALL use log2(FIFO_DEPTH)+1 bits so that full and empty are distinguished by the extra wrap bit.

Reset
REQ-031 When sys_rst_n=0, immediately and independent of clk: FIFO empty, out_valid=0, out_data=0, out_last=0, overflow=0, err_short=0, burst_cnt=0, beat_idx=0, state IDLE.
REQ-032 A reset in the middle of a burst SHALL discard all buffered words; the first valid beat after release SHALL be treated as beat 0.

Configuration
REQ-033 With macro RSA_RES_ERR_EN defined, the short-burst detection of REQ-027 SHALL be present.
REQ-034 Without RSA_RES_ERR_EN, err_short SHALL be tied to 0, gaps SHALL NOT reset beat_idx, and bursts SHALL be delimited purely by beat count.

Structure
REQ-035 A shared package SHALL hold RSA_DW, the Q1.12.19 field constants (INT_BIT=12, DEC_BIT=19), and the FSM state enum.
REQ-036 The FIFO SHALL be the sub-module rsa_res_fifo (FWFT, storing RSA_DW+1 bits per entry); the FSM, counters and flags SHALL live in the top.

Verification (ROW_LEN=4, FIFO_DEPTH=8)
REQ-037 Burst of 4 consecutive beats 10,-20,30,-40 with out_ready=1 -> out_data 10,-20,30,-40 on consecutive cycles starting 1 cycle after the first beat; out_last=1 only on -40; burst_cnt=1.
REQ-038 out_ready=0 and 3 bursts (12 beats) -> the first 8 are stored, overflow=1, burst_cnt=3; draining the FIFO yields out_last on words 4 and 8.
REQ-039 FIFO full with out_ready=1 and a same-cycle beat -> the beat is stored and overflow stays 0.
REQ-040 With RSA_RES_ERR_EN: 2 beats then a gap -> err_short pulses for 1 cycle, the next beat is treated as beat_idx 0, burst_cnt is unchanged; without the macro, err_short stays 0 and beat_idx continues from 2.
REQ-041 sys_rst_n pulled low asynchronously mid-burst with 5 words buffered -> out_valid=0 with no clock edge; after release, a new 4-beat burst is output correctly.
REQ-042 clr asserted in the same cycle as a completing burst -> burst_cnt=0 and overflow=0 at the next edge.

Source files
------------

// File: rtl/rsa_res_collect_pkg.sv
// Shared constants and types for the systolic-array result collector.
// Holds the Q1.12.19 word layout and the collector FSM state encoding.
package rsa_res_collect_pkg;

  localparam int RSA_DW  = 32;
  localparam int INT_BIT = 12;
  localparam int DEC_BIT = 19;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/rsa_res_fifo.sv
// First-word-fall-through result buffer (head visible the cycle after write).
// Ports: clk, rst_n, wr_en/wr_data, rd_en -> rd_data, empty, full.
module rsa_res_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];

  logic rd_ok;
  logic wr_ok;

  // Extra pointer bit separates full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign rd_ok = rd_en && !empty;
  // A same-cycle read frees the slot being written.
  assign wr_ok = wr_en && (!full || rd_ok);

  // Empty presents zero so the output is clean straight out of reset.
  assign rd_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_ok) wr_q <= wr_q + 1'b1;
      if (rd_ok) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rsa_res_collect.sv
// Collects west-edge PE results into bursts of ROW_LEN words with a FWFT buffer.
// Ports: mulres_* in, out_valid/ready/data/last, clr, overflow, err_short,
// burst_cnt. Macro RSA_RES_ERR_EN enables short-burst detection.
module rsa_res_collect
  import rsa_res_collect_pkg::*;
#(
  parameter int RSA_DW     = rsa_res_collect_pkg::RSA_DW,
  parameter int ROW_LEN    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     sys_rst_n,
  input  logic                     mulres_val_in,
  input  logic signed [RSA_DW-1:0] mulres_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [RSA_DW-1:0] out_data,
  output logic                     out_last,
  input  logic                     clr,
  output logic                     overflow,
  output logic                     err_short,
  output logic [15:0]              burst_cnt
);

  localparam int IW = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;
  localparam int FW = RSA_DW + 1;

  state_e        state_q;
  logic [IW-1:0] beat_idx_q;
  logic          overflow_q;
  logic          err_short_q;
  logic [15:0]   burst_cnt_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic [FW-1:0] fifo_rd;
  logic          last_beat;
  logic          rd_fire;
  logic          drop;

  assign last_beat = (beat_idx_q == IW'(ROW_LEN - 1));
  assign rd_fire   = out_valid && out_ready;
  // Beats cannot be stalled; anything that does not fit is lost.
  assign drop      = mulres_val_in && fifo_full && !rd_fire;

  rsa_res_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .wr_en   (mulres_val_in),
    .wr_data ({last_beat, mulres_in}),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd[RSA_DW-1:0];
  assign out_last  = fifo_rd[FW-1];

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      beat_idx_q  <= '0;
      overflow_q  <= 1'b0;
      err_short_q <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      err_short_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // ROW_LEN >= 2, so beat 0 never closes a burst.
          if (mulres_val_in) begin
            beat_idx_q <= beat_idx_q + 1'b1;
            state_q    <= COLLECT;
          end
        end
        COLLECT: begin
          if (mulres_val_in) begin
            if (last_beat) begin
              beat_idx_q  <= '0;
              state_q     <= IDLE;
              burst_cnt_q <= burst_cnt_q + 16'd1;
            end else begin
              beat_idx_q <= beat_idx_q + 1'b1;
            end
          end
`ifdef RSA_RES_ERR_EN
          else begin
            beat_idx_q  <= '0;
            state_q     <= IDLE;
            err_short_q <= 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
      if (drop) overflow_q <= 1'b1;
      if (clr) begin
        overflow_q  <= 1'b0;
        burst_cnt_q <= '0;
      end
    end
  end

  assign overflow  = overflow_q;
  assign err_short = err_short_q;
  assign burst_cnt = burst_cnt_q;

endmodule
